// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg: controller state encoding and geometry helper functions.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_FILL   = 3'd2,
    S_CWRITE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  function automatic int words(input int off_w);
    return 1 << (off_w - 1);
  endfunction

  function automatic int addr_w(input int tag_w, input int idx_w, input int off_w);
    return tag_w + idx_w + off_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_lru_array.sv
// ---------------------------------------------------------------------------
// cache_lru_array: one LRU bit per set, one read and one write port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cache_lru_array #(
  parameter int IDX_W  = 8,
  parameter bit ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_val_o,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_val_i,
  input  logic             wr_en_i
);

  localparam int SETS = 1 << IDX_W;

  generate
    if (ENABLE) begin : g_lru
      logic [SETS-1:0] lru_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)          lru_q <= '0;
        else if (wr_en_i) lru_q[wr_idx_i] <= wr_val_i;
      end

      assign rd_val_o = lru_q[rd_idx_i];
    end else begin : g_tie
      // A direct-mapped cache has no replacement choice to remember.
      logic unused_lru;
      assign unused_lru = ^{clk, rst, rd_idx_i, wr_idx_i, wr_val_i, wr_en_i};
      assign rd_val_o   = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dff.sv
// ---------------------------------------------------------------------------
// dff: parameterised register with asynchronous active-high reset.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_o <= RST_VAL;
    else     q_o <= d_i;
  end

endmodule

`default_nettype wire

// File: rtl/cache_ctrl_nway.sv
// ---------------------------------------------------------------------------
// cache_ctrl_nway: write-back, write-allocate controller for a 1/2-way cache.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int IDX_W   = 8,
  parameter int OFF_W   = 3,
  parameter int WAYS    = 2,
  parameter int MEM_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Rd,
  input  logic                          Wr,
  input  logic [TAG_W-1:0]              tag_in,
  input  logic [IDX_W-1:0]              index_in,
  input  logic [OFF_W-1:0]              offset_in,
  input  logic [WAYS-1:0]               hit,
  input  logic [WAYS-1:0]               valid,
  input  logic [WAYS-1:0]               dirty,
  input  logic [WAYS*TAG_W-1:0]         tag_out,
  input  logic                          mem_stall,
  output logic [WAYS-1:0]               way_sel,
  output logic                          comp,
  output logic                          write,
  output logic                          valid_in,
  output logic                          cache_in,
  output logic                          mem_in,
  output logic [OFF_W-1:0]              offset_out,
  output logic [TAG_W+IDX_W+OFF_W-1:0]  mem_addr,
  output logic                          read_mem,
  output logic                          write_mem,
  output logic                          Stall,
  output logic                          CacheHit,
  output logic                          done
);

  localparam int WORDS = words(OFF_W);
  localparam int AW    = addr_w(TAG_W, IDX_W, OFF_W);
  localparam int WB    = OFF_W - 1;
  localparam int BW    = OFF_W;
  localparam int SW    = WB + 1;
  localparam int SR_W  = MEM_LAT * SW;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
  localparam logic [BW-1:0] ALL_BEATS = BW'(WORDS);

  logic [STATE_W-1:0] state_raw_q;
  state_e             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [SW-1:0]      sr_in;
  logic [WAYS-1:0]    victim_q, victim_d;

  dff #(.WIDTH(STATE_W)) u_state  (.clk(clk), .rst(rst), .d_i(state_d),  .q_o(state_raw_q));
  dff #(.WIDTH(BW))      u_beat   (.clk(clk), .rst(rst), .d_i(beat_d),   .q_o(beat_q));
  dff #(.WIDTH(SR_W))    u_sr     (.clk(clk), .rst(rst), .d_i(sr_d),     .q_o(sr_q));
  dff #(.WIDTH(WAYS))    u_victim (.clk(clk), .rst(rst), .d_i(victim_d), .q_o(victim_q));

  assign state_q = state_e'(state_raw_q);

  // Stage 0 takes the newest beat; the top stage is the word arriving now.
  generate
    if (MEM_LAT > 1) begin : g_sr_shift
      assign sr_d = {sr_q[SR_W-SW-1:0], sr_in};
    end else begin : g_sr_single
      assign sr_d = sr_in;
    end
  endgenerate

  logic          ret_vld;
  logic [WB-1:0] ret_word;
  logic          pend;

  assign ret_vld  = sr_q[SR_W-1];
  assign ret_word = sr_q[SR_W-2 -: WB];

  always_comb begin
    pend = 1'b0;
    for (int s = 0; s < MEM_LAT - 1; s++) pend = pend | sr_q[s*SW + WB];
  end

  logic            req, is_wr, is_rd, any_hit;
  logic [WAYS-1:0] hv, hit_oh, inv_oh, victim_sel;
  logic            hit_idx, victim_idx, victim_dirty, lru_rd;
  logic [TAG_W-1:0] vtag;
  logic            lru_we, lru_wval;

  assign req     = Rd | Wr;
  assign is_wr   = Wr;
  assign is_rd   = Rd & ~Wr;
  assign hv      = hit & valid;
  assign any_hit = |hv;

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit_oh  = '0;
    inv_oh  = '0;
    hit_idx = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hv[w]) begin
        hit_oh    = '0;
        hit_oh[w] = 1'b1;
        hit_idx   = (w != 0);
      end
      if (!valid[w]) begin
        inv_oh    = '0;
        inv_oh[w] = 1'b1;
      end
    end
  end

  always_comb begin
    victim_sel = '0;
    if (|inv_oh) begin
      victim_sel = inv_oh;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if ((w != 0) == lru_rd) victim_sel[w] = 1'b1;
      end
    end
  end

  assign victim_dirty = |(victim_sel & dirty);

  always_comb begin
    victim_idx = 1'b0;
    vtag       = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (victim_q[w]) begin
        victim_idx = (w != 0);
        vtag       = tag_out[w*TAG_W +: TAG_W];
      end
    end
  end

  cache_lru_array #(
    .IDX_W  (IDX_W),
    .ENABLE (WAYS > 1)
  ) u_lru (
    .clk      (clk),
    .rst      (rst),
    .rd_idx_i (index_in),
    .rd_val_o (lru_rd),
    .wr_idx_i (index_in),
    .wr_val_i (lru_wval),
    .wr_en_i  (lru_we)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    victim_d   = victim_q;
    sr_in      = '0;
    lru_we     = 1'b0;
    lru_wval   = 1'b0;
    way_sel    = '0;
    comp       = 1'b0;
    write      = 1'b0;
    valid_in   = 1'b0;
    cache_in   = 1'b0;
    mem_in     = 1'b0;
    offset_out = offset_in;
    mem_addr   = '0;
    read_mem   = 1'b0;
    write_mem  = 1'b0;
    Stall      = 1'b1;
    CacheHit   = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        Stall  = 1'b0;
        beat_d = '0;
        if (req) begin
          comp    = 1'b1;
          way_sel = '1;
          if (any_hit) begin
            CacheHit = 1'b1;
            done     = 1'b1;
            way_sel  = hit_oh;
            if (is_wr) begin
              write    = 1'b1;
              valid_in = 1'b1;
            end else begin
              cache_in = 1'b1;
            end
            lru_we   = 1'b1;
            lru_wval = ~hit_idx;
          end else begin
            victim_d = victim_sel;
            state_d  = victim_dirty ? S_WB : S_FILL;
          end
        end
      end

      S_WB: begin
        write_mem  = 1'b1;
        mem_in     = 1'b1;
        way_sel    = victim_q;
        offset_out = {beat_q[WB-1:0], 1'b0};
        mem_addr   = AW'({vtag, index_in, beat_q[WB-1:0], 1'b0});
        if (!mem_stall) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_FILL: begin
        if (beat_q < ALL_BEATS) begin
          read_mem = 1'b1;
          mem_addr = AW'({tag_in, index_in, beat_q[WB-1:0], 1'b0});
          if (!mem_stall) begin
            sr_in  = {1'b1, beat_q[WB-1:0]};
            beat_d = beat_q + 1'b1;
          end
        end else if (!pend) begin
          // Last word is on the return port now; nothing else is in flight.
          beat_d   = '0;
          lru_we   = 1'b1;
          lru_wval = ~victim_idx;
          state_d  = is_wr ? S_CWRITE : S_DONE;
        end
        if (ret_vld) begin
          write      = 1'b1;
          valid_in   = 1'b1;
          cache_in   = 1'b1;
          way_sel    = victim_q;
          offset_out = {ret_word, 1'b0};
        end
      end

      S_CWRITE: begin
        comp     = 1'b1;
        write    = 1'b1;
        valid_in = 1'b1;
        way_sel  = victim_q;
        state_d  = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        way_sel = victim_q;
        if (is_rd) begin
          comp     = 1'b1;
          cache_in = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl_nway.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_nway: directed vectors and hand-scheduled miss sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cache_ctrl_nway;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rd, wr, stall;
  logic [4:0]  tag;
  logic [7:0]  idx;
  logic [2:0]  off;
  logic [1:0]  hit, valid, dirty;
  logic [9:0]  tag_out;
  logic [1:0]  way_sel;
  logic        comp, write, valid_in, cache_in, mem_in, read_mem, write_mem;
  logic        Stall, CacheHit, done;
  logic [2:0]  offset_out;
  logic [15:0] mem_addr;
  logic [12:0] outs;

  assign outs = {way_sel, comp, write, valid_in, cache_in, mem_in,
                 read_mem, write_mem, Stall, CacheHit, done};

  cache_ctrl_nway #(.TAG_W(5), .IDX_W(8), .OFF_W(3), .WAYS(2), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .Rd(rd), .Wr(wr),
    .tag_in(tag), .index_in(idx), .offset_in(off),
    .hit(hit), .valid(valid), .dirty(dirty), .tag_out(tag_out), .mem_stall(stall),
    .way_sel(way_sel), .comp(comp), .write(write), .valid_in(valid_in),
    .cache_in(cache_in), .mem_in(mem_in), .offset_out(offset_out), .mem_addr(mem_addr),
    .read_mem(read_mem), .write_mem(write_mem), .Stall(Stall), .CacheHit(CacheHit),
    .done(done)
  );

  // Direct-mapped, 8-word line, 3-cycle memory instance
  logic        b_rd, b_wr, b_stall;
  logic [4:0]  b_tag;
  logic [7:0]  b_idx;
  logic [3:0]  b_off;
  logic [0:0]  b_hit, b_valid, b_dirty;
  logic [4:0]  b_tag_out;
  logic [0:0]  b_way_sel;
  logic        b_comp, b_write, b_valid_in, b_cache_in, b_mem_in, b_read_mem, b_write_mem;
  logic        b_Stall, b_CacheHit, b_done;
  logic [3:0]  b_offset_out;
  logic [16:0] b_mem_addr;

  cache_ctrl_nway #(.TAG_W(5), .IDX_W(8), .OFF_W(4), .WAYS(1), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .Rd(b_rd), .Wr(b_wr),
    .tag_in(b_tag), .index_in(b_idx), .offset_in(b_off),
    .hit(b_hit), .valid(b_valid), .dirty(b_dirty), .tag_out(b_tag_out), .mem_stall(b_stall),
    .way_sel(b_way_sel), .comp(b_comp), .write(b_write), .valid_in(b_valid_in),
    .cache_in(b_cache_in), .mem_in(b_mem_in), .offset_out(b_offset_out), .mem_addr(b_mem_addr),
    .read_mem(b_read_mem), .write_mem(b_write_mem), .Stall(b_Stall), .CacheHit(b_CacheHit),
    .done(b_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic [1:0] ws, input logic cm, input logic wt,
                                     input logic vi, input logic ci, input logic mi,
                                     input logic rm, input logic wm, input logic st,
                                     input logic ch, input logic dn);
    return {ws, cm, wt, vi, ci, mi, rm, wm, st, ch, dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [1:0] hit;
    logic [1:0] valid;
    logic [2:0] off;
    logic [12:0] exp;
  } vec_t;
  vec_t vt[6];

  typedef enum int {P_M, P_B, P_F, P_C, P_D, P_I} ph_e;
  typedef struct {
    ph_e  ph;
    int   ib;
    int   rw;
    logic st;
  } cyc_t;
  cyc_t sq[$];

  function automatic cyc_t cy(input ph_e p, input int ib, input int rw, input logic st);
    cyc_t e;
    e.ph = p; e.ib = ib; e.rw = rw; e.st = st;
    return e;
  endfunction

  // Hand schedule for an unstalled miss with default geometry.
  task automatic build(input bit dirty_v, input bit wreq);
    sq.delete();
    sq.push_back(cy(P_M, -1, -1, 0));
    if (dirty_v) for (int b = 0; b < 4; b++) sq.push_back(cy(P_B, b, -1, 0));
    sq.push_back(cy(P_F, 0, -1, 0));
    sq.push_back(cy(P_F, 1, -1, 0));
    sq.push_back(cy(P_F, 2, 0, 0));
    sq.push_back(cy(P_F, 3, 1, 0));
    sq.push_back(cy(P_F, -1, 2, 0));
    sq.push_back(cy(P_F, -1, 3, 0));
    if (wreq) sq.push_back(cy(P_C, -1, -1, 0));
    sq.push_back(cy(P_D, -1, -1, 0));
    sq.push_back(cy(P_I, -1, -1, 0));
  endtask

  task automatic run_seq(input string nm, input logic r, input logic w,
                         input logic [1:0] vs, input logic [4:0] vtag);
    for (int c = 0; c < sq.size(); c++) begin
      cyc_t        e;
      logic [12:0] eo;
      logic [2:0]  eoff;
      logic [15:0] ea;
      logic [1:0]  ib2, rw2;
      logic        ibv, rwv;
      e     = sq[c];
      stall = e.st;
      if (e.ph == P_I) begin rd = 1'b0; wr = 1'b0; end
      else begin rd = r; wr = w; end
      #1;
      ibv  = (e.ib >= 0);
      rwv  = (e.rw >= 0);
      ib2  = 2'(e.ib);
      rw2  = 2'(e.rw);
      eo   = '0;
      eoff = off;
      ea   = '0;
      case (e.ph)
        P_M: eo = mk(2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        P_B: begin
          eo   = mk(vs, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
          eoff = {ib2, 1'b0};
          ea   = {vtag, idx, ib2, 1'b0};
        end
        P_F: begin
          eo = mk(rwv ? vs : 2'b00, 0, rwv, rwv, rwv, 0, ibv, 0, 1, 0, 0);
          if (ibv) ea = {tag, idx, ib2, 1'b0};
          if (rwv) eoff = {rw2, 1'b0};
        end
        P_C: eo = mk(vs, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        P_D: eo = mk(vs, ~w, 0, 0, ~w, 0, 0, 0, 1, 0, 1);
        default: eo = '0;
      endcase
      chk($sformatf("%s c%0d outs", nm, c), 32'(outs), 32'(eo));
      chk($sformatf("%s c%0d offset_out", nm, c), 32'(offset_out), 32'(eoff));
      chk($sformatf("%s c%0d mem_addr", nm, c), 32'(mem_addr), 32'(ea));
      step();
    end
    stall = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 2'b11, 2'b11, 3'b101, mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vt[1] = '{1'b1, 1'b0, 2'b10, 2'b11, 3'b011, mk(2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1)};
    vt[2] = '{1'b0, 1'b1, 2'b01, 2'b01, 3'b110, mk(2'b01, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1)};
    vt[3] = '{1'b1, 1'b1, 2'b11, 2'b11, 3'b001, mk(2'b01, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1)};
    vt[4] = '{1'b1, 1'b0, 2'b11, 2'b10, 3'b111, mk(2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1)};
    vt[5] = '{1'b0, 1'b1, 2'b10, 2'b10, 3'b010, mk(2'b10, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1)};

    rd = 0; wr = 0; stall = 0; tag = 0; idx = 0; off = 3'b101;
    hit = 0; valid = 0; dirty = 0; tag_out = 0;
    b_rd = 0; b_wr = 0; b_stall = 0; b_tag = 0; b_idx = 0; b_off = 0;
    b_hit = 0; b_valid = 0; b_dirty = 0; b_tag_out = 0;

    #2 rst = 1'b1;
    #1;
    chk("reset outs", 32'(outs), 32'd0);
    chk("reset offset_out", 32'(offset_out), 32'(off));
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post-reset outs", 32'(outs), 32'd0);

    // Single-cycle IDLE vectors: idle/hit decoding
    idx = 8'h10;
    for (int i = 0; i < 6; i++) begin
      rd = vt[i].rd; wr = vt[i].wr; hit = vt[i].hit; valid = vt[i].valid; off = vt[i].off;
      #1;
      chk($sformatf("vec%0d outs", i), 32'(outs), 32'(vt[i].exp));
      chk($sformatf("vec%0d offset_out", i), 32'(offset_out), 32'(vt[i].off));
      chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'd0);
      step();
    end
    rd = 0; wr = 0; hit = 0; off = 3'b100;

    // Hit on way 1 leaves LRU pointing at way 0
    idx = 8'h3C; tag = 5'h07; valid = 2'b11; hit = 2'b10; rd = 1;
    #1;
    chk("lru hit outs", 32'(outs), 32'(mk(2'b10, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1)));
    step();
    hit = 2'b00;
    build(0, 0);
    run_seq("rd miss lru0", 1, 0, 2'b01, 5'h00);

    // That fill made way 1 least recent
    tag = 5'h09;
    build(0, 0);
    run_seq("rd miss lru1", 1, 0, 2'b10, 5'h00);

    // Write miss, dirty victim way 0
    tag = 5'h0E; dirty = 2'b01; tag_out = {5'h00, 5'h1A};
    build(1, 1);
    run_seq("wr miss dirty", 0, 1, 2'b01, 5'h1A);
    dirty = 2'b00;

    // Stall on second fill issue; both ways invalid so way 0 is chosen
    idx = 8'h55; tag = 5'h03; valid = 2'b00;
    sq.delete();
    sq.push_back(cy(P_M, -1, -1, 0));
    sq.push_back(cy(P_F, 0, -1, 0));
    sq.push_back(cy(P_F, 1, -1, 1));
    sq.push_back(cy(P_F, 1, 0, 0));
    sq.push_back(cy(P_F, 2, -1, 0));
    sq.push_back(cy(P_F, 3, 1, 0));
    sq.push_back(cy(P_F, -1, 2, 0));
    sq.push_back(cy(P_F, -1, 3, 0));
    sq.push_back(cy(P_D, -1, -1, 0));
    sq.push_back(cy(P_I, -1, -1, 0));
    run_seq("stall issue1", 1, 0, 2'b01, 5'h00);

    // Stall while a return is in flight
    sq.delete();
    sq.push_back(cy(P_M, -1, -1, 0));
    sq.push_back(cy(P_F, 0, -1, 0));
    sq.push_back(cy(P_F, 1, -1, 0));
    sq.push_back(cy(P_F, 2, 0, 1));
    sq.push_back(cy(P_F, 2, 1, 0));
    sq.push_back(cy(P_F, 3, -1, 0));
    sq.push_back(cy(P_F, -1, 2, 0));
    sq.push_back(cy(P_F, -1, 3, 0));
    sq.push_back(cy(P_D, -1, -1, 0));
    sq.push_back(cy(P_I, -1, -1, 0));
    run_seq("stall issue2", 1, 0, 2'b01, 5'h00);

    // Reset in the middle of a write-back (victim way 1, LRU=1 at 0x3C)
    idx = 8'h3C; tag = 5'h11; valid = 2'b11; dirty = 2'b10; tag_out = {5'h0B, 5'h1A};
    sq.delete();
    sq.push_back(cy(P_M, -1, -1, 0));
    sq.push_back(cy(P_B, 0, -1, 0));
    run_seq("wb before rst", 0, 1, 2'b10, 5'h0B);
    #2;
    rst = 1'b1; rd = 0; wr = 0;
    #1;
    chk("mid-wb rst outs", 32'(outs), 32'd0);
    chk("mid-wb rst mem_addr", 32'(mem_addr), 32'd0);
    chk("mid-wb rst offset_out", 32'(offset_out), 32'(off));
    step();
    rst = 1'b0;
    #1;
    chk("after rst outs", 32'(outs), 32'd0);
    step();

    // Cleared LRU at 0x3C selects way 0 again
    dirty = 2'b00; tag = 5'h15;
    build(0, 0);
    run_seq("rd miss after rst", 1, 0, 2'b01, 5'h00);

    // Direct-mapped instance: 8 issues, 3-cycle latency, done in cycle 12
    begin
      int nissue;
      nissue = 0;
      b_tag = 5'h13; b_idx = 8'hA7; b_off = 4'h6; b_valid = 1'b1; b_hit = 1'b0; b_rd = 1'b1;
      for (int c = 0; c <= 13; c++) begin
        logic       iss, ret, dn;
        logic [3:0] eb;
        logic [2:0] cb;
        if (c == 13) b_rd = 1'b0;
        #1;
        iss = (c >= 1) && (c <= 8);
        ret = (c >= 4) && (c <= 11);
        dn  = (c == 12);
        eb  = {iss, ret, dn, (ret || dn || c == 0)};
        chk($sformatf("w1 c%0d rm/wr/done/ws", c),
            32'({b_read_mem, b_write, b_done, b_way_sel}), 32'(eb));
        if (iss) begin
          cb = 3'(c - 1);
          chk($sformatf("w1 c%0d mem_addr", c), 32'(b_mem_addr), 32'({b_tag, b_idx, cb, 1'b0}));
        end
        if (ret) begin
          cb = 3'(c - 4);
          chk($sformatf("w1 c%0d offset_out", c), 32'(b_offset_out), 32'({cb, 1'b0}));
        end
        if (b_read_mem) nissue++;
        step();
      end
      chk("w1 issue count", 32'(nissue), 32'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
